// File: rtl/cr_cceip_64_sa_pkg.sv
// Shared definitions for the stats-aggregator readout block: register read
// address field positions, bus word width and the dump engine state type.
package cr_cceip_64_saPKG;

    // Register read bus word width
    localparam int WORD_W     = 32;

    // rd_addr layout: [7] snapshot/live select, [6:1] counter index, [0] high/low word
    localparam int RD_SEL_BIT = 7;
    localparam int RD_IDX_MSB = 6;
    localparam int RD_IDX_LSB = 1;
    localparam int RD_HI_BIT  = 0;
    localparam int IDX_W      = RD_IDX_MSB - RD_IDX_LSB + 1;

    // Dump word layout: {index, 8'd0, value}
    localparam int DUMP_VAL_W = 50;
    localparam int DUMP_PAD_W = 8;
    localparam int DUMP_W     = 64;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

    // Assemble one dump word from its index and a 50-bit value
    function automatic logic [DUMP_W-1:0] dump_word(input logic [IDX_W-1:0]      idx,
                                                     input logic [DUMP_VAL_W-1:0] val);
        return {idx, {DUMP_PAD_W{1'b0}}, val};
    endfunction

endpackage

// File: rtl/cr_cceip_64_sa_dump.sv
// Snapshot dump engine: streams all snapshot counters, one word per
// accepted valid/ready handshake, then pulses dump_done for one cycle.
module cr_cceip_64_sa_dump
    import cr_cceip_64_saPKG::*;
#(
    parameter int NUM_CNT = 64,
    parameter int CNT_W   = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  sa_snapshot [NUM_CNT],
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [DUMP_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    dump_state_e      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt_p0;
    logic             last_p0;

    // Zero-extend (or trim) a counter value to the 50-bit dump field
    function automatic logic [DUMP_VAL_W-1:0] fit_val(input logic [CNT_W-1:0] v);
        logic [63:0] wide;
        wide = 64'(v);
        return wide[DUMP_VAL_W-1:0];
    endfunction

    assign idx_nxt_p0 = idx + IDX_W'(1);
    assign last_p0    = (idx == IDX_W'(NUM_CNT - 1));

    // Dump FSM: next word is loaded on the accepting edge so a ready sink sees no bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= DUMP_IDLE;
            idx        <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (dump_start) begin
                        state      <= DUMP_SEND;
                        idx        <= '0;
                        dump_data  <= dump_word('0, fit_val(sa_snapshot[0]));
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                    end
                end
                DUMP_SEND: begin
                    if (dump_valid && dump_ready) begin
                        if (last_p0) begin
                            state      <= DUMP_DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            idx       <= idx_nxt_p0;
                            dump_data <= dump_word(idx_nxt_p0, fit_val(sa_snapshot[idx_nxt_p0]));
                        end
                    end
                end
                DUMP_DONE: begin
                    state     <= DUMP_IDLE;
                    dump_done <= 1'b0;
                    dump_busy <= 1'b0;
                end
                default: begin
                    state      <= DUMP_IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cr_cceip_64_sa_rdout.sv
// Stats aggregator readout: 32-bit register reads of live/snapshot counters
// with a low-word-then-high-word coherent hold, plus an optional snapshot
// dump stream. The dump engine is built only when CR_CCEIP_SA_RDOUT_DUMP_EN
// is defined; otherwise the dump outputs are tied low.
module cr_cceip_64_sa_rdout
    import cr_cceip_64_saPKG::*;
#(
    parameter int NUM_CNT = 64,
    parameter int CNT_W   = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  sa_snapshot [NUM_CNT],
    input  logic [CNT_W-1:0]  sa_count    [NUM_CNT],
    input  logic              rd_req,
    input  logic [7:0]        rd_addr,
    output logic              rd_ack,
    output logic [WORD_W-1:0] rd_data,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DUMP_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int HI_W = CNT_W - WORD_W;

    logic [IDX_W-1:0] rd_idx_p0;
    logic             rd_snap_p0;
    logic             rd_hi_p0;
    logic [CNT_W-1:0] sel_val_p0;
    logic             hold_hit_p0;

    logic             hold_valid;
    logic [IDX_W:0]   hold_tag;
    logic [HI_W-1:0]  hold_data;

    assign rd_idx_p0   = rd_addr[RD_IDX_MSB:RD_IDX_LSB];
    assign rd_snap_p0  = rd_addr[RD_SEL_BIT];
    assign rd_hi_p0    = rd_addr[RD_HI_BIT];
    assign sel_val_p0  = rd_snap_p0 ? sa_snapshot[rd_idx_p0] : sa_count[rd_idx_p0];
    assign hold_hit_p0 = hold_valid && (hold_tag == {rd_snap_p0, rd_idx_p0});

    // Read response: ack one cycle after the strobe, data held between acks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ack     <= 1'b0;
            rd_data    <= '0;
            hold_valid <= 1'b0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                if (!rd_hi_p0) begin
                    rd_data    <= sel_val_p0[WORD_W-1:0];
                    hold_valid <= 1'b1;
                end else if (hold_hit_p0) begin
                    rd_data    <= WORD_W'(hold_data);
                    hold_valid <= 1'b0;
                end else begin
                    rd_data    <= WORD_W'(sel_val_p0[CNT_W-1:WORD_W]);
                end
            end
        end
    end

    // Hold register: every low-word read captures the matching upper bits and tag
    always_ff @(posedge clk) begin
        if (rd_req && !rd_hi_p0) begin
            hold_data <= sel_val_p0[CNT_W-1:WORD_W];
            hold_tag  <= {rd_snap_p0, rd_idx_p0};
        end
    end

`ifdef CR_CCEIP_SA_RDOUT_DUMP_EN
    cr_cceip_64_sa_dump #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W)
    ) u_dump (
        .clk         (clk),
        .rst_n       (rst_n),
        .sa_snapshot (sa_snapshot),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .dump_valid  (dump_valid),
        .dump_data   (dump_data),
        .dump_busy   (dump_busy),
        .dump_done   (dump_done)
    );
`else
    logic unused_dump_in;
    assign unused_dump_in = dump_start ^ dump_ready;
    assign dump_valid     = 1'b0;
    assign dump_data      = '0;
    assign dump_busy      = 1'b0;
    assign dump_done      = 1'b0;
`endif

endmodule
